alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, the operand and result width.
REQ-002 SHALL have parameter CTRL_W, default 5, the ALU opcode width.
REQ-003 SHALL have parameter ALU_LAT, default 1 (legal 1..15), the clk cycles from operands applied to alu_y/alu_cout valid.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 req0_valid / req1_valid  in  1 each  requester N has an operation pending.
REQ-007 req0_ready / req1_ready  out  1 each  operation from requester N accepted this cycle.
REQ-008 req0_a, req0_b / req1_a, req1_b  in  DATA_W each  operands from requester N.
REQ-009 req0_ctrl / req1_ctrl  in  CTRL_W  opcode from requester N.
REQ-010 rsp_valid  out  1  result held for the consumer.
REQ-011 rsp_ready  in  1  consumer takes the result.
REQ-012 rsp_id  out  1  requester that owns the result.
REQ-013 rsp_y  out  DATA_W, rsp_cout  out  1  captured ALU result and carry.
REQ-014 alu_a, alu_b  out  DATA_W, alu_ctrl  out  CTRL_W  registered drive to the shared ALU.
REQ-015 alu_y  in  DATA_W, alu_cout  in  1  ALU result inputs.

Function
REQ-016 SHALL implement FSM states IDLE, EXEC, DONE.
REQ-017 In IDLE, reqN_ready SHALL be combinational: 1 only for the granted requester, and only when its valid is high; both readies are 0 in every other state.
REQ-018 Grant: one valid -> that requester; both valid -> the requester not granted last (last_grant initialised to 1 by reset, so req0 wins first).
REQ-019 On accept (valid & ready) SHALL latch a, b, ctrl into alu_a/alu_b/alu_ctrl, record rsp_id, update last_grant, load the latency counter with ALU_LAT, enter EXEC.
REQ-020 In EXEC the counter SHALL decrement each cycle; on the cycle it reads 1, capture alu_y/alu_cout into rsp_y/rsp_cout and enter DONE.
REQ-021 In DONE, rsp_valid SHALL be 1 and rsp_y/rsp_cout/rsp_id stable until rsp_valid & rsp_ready, then return to IDLE next cycle.
REQ-022 alu_a/alu_b/alu_ctrl SHALL hold their last value outside accept cycles.
REQ-023 Throughput: accept-to-rsp_valid = ALU_LAT+1 cycles; with rsp_ready held high, back-to-back accepts are ALU_LAT+2 cycles apart.
REQ-024 A valid dropped before acceptance SHALL be ignored; requests arriving during EXEC/DONE SHALL wait, never be lost or merged.
REQ-025 Counter width SHALL be 4 bits; no wrap behaviour permitted.

Reset
REQ-026 Asserting rst in any state (including mid-EXEC or DONE with rsp_ready low) SHALL immediately force IDLE, rsp_valid=0, readies=0, discarding the in-flight operation.
REQ-027 Reset values: alu_a=0, alu_b=0, alu_ctrl=0, rsp_y=0, rsp_cout=0, rsp_id=0, counter=0, last_grant=1.
REQ-028 First accept SHALL be possible in the first clk edge after rst deasserts.

Structure
REQ-029 Package alu_arb_pkg SHALL hold the FSM state type, DATA_W/CTRL_W defaults, and requester-ID width.
REQ-030 Grant logic SHALL be a sub-module rr_arb2 (two-way round-robin: inputs valid0/valid1/last_grant, outputs grant0/grant1); FSM, counter and datapath registers stay in alu_arbiter.

Verification (bench ALU model: ctrl 0 -> y=a+b with carry out, ALU_LAT=1)
REQ-031 req0: a=16, b=3, ctrl=0 -> req0_ready 1 cycle, rsp_valid 2 cycles later, rsp_id=0, rsp_y=19, rsp_cout=0.
REQ-032 Both valid same cycle after reset (req0 a=1,b=1; req1 a=5,b=5) -> req0 served first (rsp_y=2, id 0), then req1 (rsp_y=10, id 1).
REQ-033 req0 held valid continuously, req1 valid -> grants strictly alternate 0,1,0,1 over 4 operations.
REQ-034 a=32'hFFFF_FFFF, b=1, ctrl=0 -> rsp_y=0, rsp_cout=1.
REQ-035 rsp_ready low 10 cycles -> rsp_valid/rsp_y stable throughout, no new req ready asserted; completes on rsp_ready=1.
REQ-036 rst pulsed during EXEC -> rsp_valid never asserts for that op, outputs at reset values, next request served normally.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared types and defaults for the two-requester ALU arbiter.
// The FSM state encoding, default widths and the requester-ID width live here.
package alu_arb_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_CTRL_W = 5;
   localparam int ID_W       = 1;
   localparam int CNT_W      = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins. When both request,
// the one that was not granted last wins (last_grant=1 means req1 went last).
module rr_arb2
   import alu_arb_pkg::*;
(
   input  logic valid0,
   input  logic valid1,
   input  logic last_grant,
   output logic grant0,
   output logic grant1
);

   assign grant0 = valid0 & (~valid1 | last_grant);
   assign grant1 = valid1 & (~valid0 | ~last_grant);

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external multi-cycle ALU between two requesters. Each accepted
// operation is driven to the ALU, waited out for ALU_LAT cycles, then held as a response.
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int CTRL_W  = DEF_CTRL_W,
   parameter int ALU_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic [CTRL_W-1:0] req0_ctrl,

   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   input  logic [CTRL_W-1:0] req1_ctrl,

   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_id,
   output logic [DATA_W-1:0] rsp_y,
   output logic              rsp_cout,

   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [CTRL_W-1:0] alu_ctrl,
   input  logic [DATA_W-1:0] alu_y,
   input  logic              alu_cout
);

   generate
      if (ALU_LAT < 1 || ALU_LAT > 15) begin : g_bad_lat
         $error("alu_arbiter: ALU_LAT must be in 1..15");
      end
   endgenerate

   state_t              r_state;
   state_t              w_state_next;

   logic [CNT_W-1:0]    r_cnt;
   logic                r_last_grant;
   logic [ID_W-1:0]     r_rsp_id;
   logic [DATA_W-1:0]   r_rsp_y;
   logic                r_rsp_cout;
   logic [DATA_W-1:0]   r_alu_a;
   logic [DATA_W-1:0]   r_alu_b;
   logic [CTRL_W-1:0]   r_alu_ctrl;

   logic                w_grant0;
   logic                w_grant1;
   logic                w_ready0;
   logic                w_ready1;
   logic                w_accept;
   logic                w_exec_last;

   rr_arb2 u_rr_arb2 (
      .valid0     (req0_valid),
      .valid1     (req1_valid),
      .last_grant (r_last_grant),
      .grant0     (w_grant0),
      .grant1     (w_grant1)
   );

   assign w_accept    = w_ready0 | w_ready1;
   // Counter never drops below 1 while in EXEC, so <= 1 only guards against a stuck FSM.
   assign w_exec_last = (r_state == ST_EXEC) && (r_cnt <= CNT_W'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (w_accept)    w_state_next = ST_EXEC;
         ST_EXEC: if (w_exec_last) w_state_next = ST_DONE;
         ST_DONE: if (rsp_ready)   w_state_next = ST_IDLE;
         default:                  w_state_next = ST_IDLE;
      endcase
   end

   // Readies are gated by rst so nothing is offered while reset is held.
   always_comb begin
      w_ready0  = 1'b0;
      w_ready1  = 1'b0;
      rsp_valid = 1'b0;
      if (r_state == ST_IDLE && !rst) begin
         w_ready0 = w_grant0;
         w_ready1 = w_grant1;
      end
      if (r_state == ST_DONE) begin
         rsp_valid = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_alu_a      <= '0;
         r_alu_b      <= '0;
         r_alu_ctrl   <= '0;
         r_rsp_id     <= '0;
         r_rsp_y      <= '0;
         r_rsp_cout   <= 1'b0;
         r_cnt        <= '0;
         r_last_grant <= 1'b1;
      end else if (w_accept) begin
         r_alu_a      <= w_ready0 ? req0_a    : req1_a;
         r_alu_b      <= w_ready0 ? req0_b    : req1_b;
         r_alu_ctrl   <= w_ready0 ? req0_ctrl : req1_ctrl;
         r_rsp_id     <= w_ready1;
         r_last_grant <= w_ready1;
         r_cnt        <= CNT_W'(ALU_LAT);
      end else if (r_state == ST_EXEC) begin
         if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
         end
         if (w_exec_last) begin
            r_rsp_y    <= alu_y;
            r_rsp_cout <= alu_cout;
         end
      end
   end

   assign req0_ready = w_ready0;
   assign req1_ready = w_ready1;
   assign rsp_id     = r_rsp_id;
   assign rsp_y      = r_rsp_y;
   assign rsp_cout   = r_rsp_cout;
   assign alu_a      = r_alu_a;
   assign alu_b      = r_alu_b;
   assign alu_ctrl   = r_alu_ctrl;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a combinational ALU stand-in:
// ctrl 0 adds with carry out, any other ctrl is a bitwise XOR.
module tb_alu_arbiter;

   logic        clk;
   logic        rst;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic [4:0]  req0_ctrl, req1_ctrl;
   logic        rsp_valid, rsp_ready, rsp_id, rsp_cout;
   logic [31:0] rsp_y;
   logic [31:0] alu_a, alu_b, alu_y;
   logic [4:0]  alu_ctrl;
   logic        alu_cout;

   int total;
   int bad;

   alu_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_ctrl  (req0_ctrl),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_ctrl  (req1_ctrl),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_y      (rsp_y),
      .rsp_cout   (rsp_cout),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_ctrl   (alu_ctrl),
      .alu_y      (alu_y),
      .alu_cout   (alu_cout)
   );

   assign {alu_cout, alu_y} = (alu_ctrl == 5'd0) ? ({1'b0, alu_a} + {1'b0, alu_b})
                                                 : {1'b0, alu_a ^ alu_b};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance from one falling edge to the next.
   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      req0_valid = 1'b1; req0_a = 32'd77; req0_b = 32'd1; req0_ctrl = 5'd0;
      tick; tick; #1;
      total++; if (req0_ready !== 1'b0) begin bad++; $display("FAIL reset_ready0 got=%b exp=0", req0_ready); end
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
      total++; if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_ctrl !== 5'd0)
         begin bad++; $display("FAIL reset_alu got=%h/%h/%h exp=0/0/0", alu_a, alu_b, alu_ctrl); end
      total++; if (rsp_y !== 32'd0 || rsp_cout !== 1'b0 || rsp_id !== 1'b0)
         begin bad++; $display("FAIL reset_rsp got=%h/%b/%b exp=0/0/0", rsp_y, rsp_cout, rsp_id); end
      @(negedge clk);
      rst = 1'b0; #1;
      total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL reset_first_ready got=%b exp=1", req0_ready); end
      req0_valid = 1'b0;
      tick; tick; tick; #1;
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_dropped_valid got=%b exp=0", rsp_valid); end
      $display("txn reset: done");
   endtask

   task automatic test_basic;
      rsp_ready = 1'b0;
      req0_a = 32'd16; req0_b = 32'd3; req0_ctrl = 5'd0; req0_valid = 1'b1; #1;
      total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL basic_ready got=%b exp=1", req0_ready); end
      total++; if (req1_ready !== 1'b0) begin bad++; $display("FAIL basic_ready1 got=%b exp=0", req1_ready); end
      tick; req0_valid = 1'b0; #1;
      total++; if (req0_ready !== 1'b0) begin bad++; $display("FAIL basic_exec_ready got=%b exp=0", req0_ready); end
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%b exp=0", rsp_valid); end
      total++; if (alu_a !== 32'd16 || alu_b !== 32'd3) begin bad++; $display("FAIL basic_alu got=%0d/%0d exp=16/3", alu_a, alu_b); end
      tick; #1;
      total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL basic_rsp_valid got=%b exp=1", rsp_valid); end
      total++; if (rsp_y !== 32'd19 || rsp_cout !== 1'b0 || rsp_id !== 1'b0)
         begin bad++; $display("FAIL basic_rsp got=%0d/%b/%b exp=19/0/0", rsp_y, rsp_cout, rsp_id); end
      rsp_ready = 1'b1;
      tick; rsp_ready = 1'b0; #1;
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL basic_release got=%b exp=0", rsp_valid); end
      $display("txn basic: y=%0d id=%0d", rsp_y, rsp_id);
   endtask

   task automatic test_both;
      rst = 1'b1; tick; rst = 1'b0;
      rsp_ready = 1'b0;
      req0_a = 32'd1; req0_b = 32'd1; req0_ctrl = 5'd0; req0_valid = 1'b1;
      req1_a = 32'd5; req1_b = 32'd5; req1_ctrl = 5'd0; req1_valid = 1'b1; #1;
      total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
         begin bad++; $display("FAIL both_first_grant got=%b%b exp=10", req0_ready, req1_ready); end
      tick; req0_valid = 1'b0; #1;
      total++; if (req1_ready !== 1'b0) begin bad++; $display("FAIL both_wait_exec got=%b exp=0", req1_ready); end
      tick; #1;
      total++; if (rsp_valid !== 1'b1 || rsp_y !== 32'd2 || rsp_id !== 1'b0)
         begin bad++; $display("FAIL both_rsp0 got=%b/%0d/%b exp=1/2/0", rsp_valid, rsp_y, rsp_id); end
      total++; if (req1_ready !== 1'b0) begin bad++; $display("FAIL both_wait_done got=%b exp=0", req1_ready); end
      rsp_ready = 1'b1;
      tick; #1;
      total++; if (req1_ready !== 1'b1) begin bad++; $display("FAIL both_second_grant got=%b exp=1", req1_ready); end
      tick; req1_valid = 1'b0;
      tick; #1;
      total++; if (rsp_valid !== 1'b1 || rsp_y !== 32'd10 || rsp_id !== 1'b1)
         begin bad++; $display("FAIL both_rsp1 got=%b/%0d/%b exp=1/10/1", rsp_valid, rsp_y, rsp_id); end
      tick;
      $display("txn both: req0 then req1 served");
   endtask

   task automatic test_back_to_back;
      int grants[4];
      int gcyc[4];
      int ng;
      int nr;
      rsp_ready = 1'b1;
      req0_a = 32'd7;  req0_b = 32'd8;  req0_ctrl = 5'd0; req0_valid = 1'b1;
      req1_a = 32'd20; req1_b = 32'd22; req1_ctrl = 5'd0; req1_valid = 1'b1;
      ng = 0; nr = 0;
      for (int c = 0; c < 60 && nr < 4; c++) begin
         #1;
         if ((req0_ready || req1_ready) && ng < 4) begin
            grants[ng] = req1_ready ? 1 : 0;
            gcyc[ng] = c;
            ng++;
         end
         if (rsp_valid) begin
            total++; if (rsp_id !== nr[0]) begin bad++; $display("FAIL b2b_rsp_id op=%0d got=%b exp=%0d", nr, rsp_id, nr % 2); end
            total++; if (rsp_y !== ((nr % 2 == 0) ? 32'd15 : 32'd42))
               begin bad++; $display("FAIL b2b_rsp_y op=%0d got=%0d exp=%0d", nr, rsp_y, (nr % 2 == 0) ? 15 : 42); end
            $display("txn b2b: op=%0d id=%0d y=%0d", nr, rsp_id, rsp_y);
            nr++;
         end
         tick;
         if (ng == 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      total++; if (nr != 4 || ng != 4) begin bad++; $display("FAIL b2b_timeout got=%0d/%0d exp=4/4", ng, nr); end
      for (int k = 0; k < ng; k++) begin
         total++; if (grants[k] != k % 2) begin bad++; $display("FAIL b2b_grant op=%0d got=%0d exp=%0d", k, grants[k], k % 2); end
         if (k > 0) begin
            total++; if (gcyc[k] - gcyc[k-1] != 3)
               begin bad++; $display("FAIL b2b_spacing op=%0d got=%0d exp=3", k, gcyc[k] - gcyc[k-1]); end
         end
      end
      tick;
   endtask

   task automatic test_carry;
      rsp_ready = 1'b1;
      req1_a = 32'hFFFF_FFFF; req1_b = 32'd1; req1_ctrl = 5'd0; req1_valid = 1'b1; #1;
      total++; if (req1_ready !== 1'b1) begin bad++; $display("FAIL carry_ready got=%b exp=1", req1_ready); end
      tick; req1_valid = 1'b0;
      tick; #1;
      total++; if (rsp_valid !== 1'b1 || rsp_y !== 32'd0 || rsp_cout !== 1'b1 || rsp_id !== 1'b1)
         begin bad++; $display("FAIL carry_rsp got=%b/%h/%b/%b exp=1/0/1/1", rsp_valid, rsp_y, rsp_cout, rsp_id); end
      $display("txn carry: y=%h cout=%b", rsp_y, rsp_cout);
      tick;
      req0_a = 32'h0000_00F0; req0_b = 32'h0000_00FF; req0_ctrl = 5'd1; req0_valid = 1'b1;
      tick; req0_valid = 1'b0; #1;
      total++; if (alu_ctrl !== 5'd1) begin bad++; $display("FAIL xor_ctrl got=%0d exp=1", alu_ctrl); end
      tick; #1;
      total++; if (rsp_valid !== 1'b1 || rsp_y !== 32'h0000_000F || rsp_cout !== 1'b0 || rsp_id !== 1'b0)
         begin bad++; $display("FAIL xor_rsp got=%b/%h/%b/%b exp=1/f/0/0", rsp_valid, rsp_y, rsp_cout, rsp_id); end
      $display("txn xor: y=%h", rsp_y);
      tick;
   endtask

   task automatic test_backpressure;
      rsp_ready = 1'b0;
      req0_a = 32'd100; req0_b = 32'd23; req0_ctrl = 5'd0; req0_valid = 1'b1; #1;
      total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL bp_ready got=%b exp=1", req0_ready); end
      tick; req0_valid = 1'b0;
      req1_a = 32'd50; req1_b = 32'd60; req1_ctrl = 5'd0; req1_valid = 1'b1; #1;
      total++; if (req1_ready !== 1'b0) begin bad++; $display("FAIL bp_exec_ready got=%b exp=0", req1_ready); end
      tick;
      for (int i = 0; i < 10; i++) begin
         if (i == 3) req0_valid = 1'b1;
         if (i == 6) req0_valid = 1'b0;
         #1;
         total++; if (rsp_valid !== 1'b1 || rsp_y !== 32'd123)
            begin bad++; $display("FAIL bp_hold cyc=%0d got=%b/%0d exp=1/123", i, rsp_valid, rsp_y); end
         total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0)
            begin bad++; $display("FAIL bp_no_ready cyc=%0d got=%b%b exp=00", i, req0_ready, req1_ready); end
         tick;
      end
      rsp_ready = 1'b1;
      tick; #1;
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_release got=%b exp=0", rsp_valid); end
      total++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0)
         begin bad++; $display("FAIL bp_waiter_grant got=%b%b exp=01", req0_ready, req1_ready); end
      tick; req1_valid = 1'b0;
      tick; #1;
      total++; if (rsp_valid !== 1'b1 || rsp_y !== 32'd110 || rsp_id !== 1'b1)
         begin bad++; $display("FAIL bp_waiter_rsp got=%b/%0d/%b exp=1/110/1", rsp_valid, rsp_y, rsp_id); end
      for (int i = 0; i < 4; i++) begin
         tick; #1;
         total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_ghost cyc=%0d got=%b exp=0", i, rsp_valid); end
      end
      $display("txn backpressure: held 123, then waiter y=110");
   endtask

   task automatic test_reset_mid;
      rsp_ready = 1'b0;
      req0_a = 32'd9; req0_b = 32'd9; req0_ctrl = 5'd0; req0_valid = 1'b1;
      tick; req0_valid = 1'b0;
      rst = 1'b1; #1;
      total++; if (rsp_valid !== 1'b0 || alu_a !== 32'd0 || alu_b !== 32'd0 || rsp_y !== 32'd0)
         begin bad++; $display("FAIL rstmid_values got=%b/%0d/%0d/%0d exp=0/0/0/0", rsp_valid, alu_a, alu_b, rsp_y); end
      tick;
      rst = 1'b0;
      req1_a = 32'd2; req1_b = 32'd3; req1_ctrl = 5'd0; req1_valid = 1'b1; #1;
      total++; if (req1_ready !== 1'b1) begin bad++; $display("FAIL rstmid_first_ready got=%b exp=1", req1_ready); end
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rstmid_lost_op got=%b exp=0", rsp_valid); end
      tick; req1_valid = 1'b0; #1;
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rstmid_exec_valid got=%b exp=0", rsp_valid); end
      tick; #1;
      total++; if (rsp_valid !== 1'b1 || rsp_y !== 32'd5 || rsp_id !== 1'b1)
         begin bad++; $display("FAIL rstmid_next_rsp got=%b/%0d/%b exp=1/5/1", rsp_valid, rsp_y, rsp_id); end
      rsp_ready = 1'b1;
      tick; rsp_ready = 1'b0;
      $display("txn reset_mid: op discarded, next y=5");
   endtask

   initial begin
      total = 0; bad = 0;
      rst = 1'b1; rsp_ready = 1'b0;
      req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_ctrl = '0;
      req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_ctrl = '0;
      @(negedge clk);
      test_reset;
      test_basic;
      test_both;
      test_back_to_back;
      test_carry;
      test_backpressure;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
